// File: rtl/clockdiv_pkg.sv
// Shared constants and helpers for the stopwatch clock divider.
package clockdiv_pkg;

    localparam int unsigned CLK_IN_HZ  = 50_000_000;
    localparam int unsigned CLK_OUT_HZ = 100;

    // Input cycles per output half period; zero flags an unusable ratio.
    function automatic int unsigned half_count(input int unsigned in_hz,
                                               input int unsigned out_hz);
        if (out_hz == 0) begin
            return 0;
        end
        return in_hz / (2 * out_hz);
    endfunction

endpackage

// File: rtl/clockdiv_modcounter.sv
// Modulo-MOD counter: counts 0..MOD-1 and flags the terminal value on wrap.
module clockdiv_modcounter #(
    parameter int unsigned MOD = 2,
    parameter int unsigned W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    // Terminal-count decode of the registered count.
    assign wrap = (cnt == W'(MOD - 1));

    // Count up, returning to zero after the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/clock_divider.sv
// 50 %-duty clock divider producing the stopwatch 100 Hz time base.
// Optional feature: define CLOCKDIV_TICK_EN to add a one-cycle 'tick'
// output that pulses with each rising edge of CLK_100Hz.
module clock_divider
    import clockdiv_pkg::*;
#(
    parameter int unsigned IN_HZ  = CLK_IN_HZ,
    parameter int unsigned OUT_HZ = CLK_OUT_HZ
) (
    input  logic CLK_50MHz,
    input  logic reset,
`ifdef CLOCKDIV_TICK_EN
    output logic tick,
`endif
    output logic CLK_100Hz
);

    localparam int unsigned HALF = half_count(IN_HZ, OUT_HZ);
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

    // Reject frequency ratios that cannot give an exact 50 % duty cycle.
    if (OUT_HZ == 0) begin : g_bad_out_hz
        $error("clock_divider: OUT_HZ must be nonzero");
    end else if ((IN_HZ % (2 * OUT_HZ)) != 0) begin : g_bad_ratio
        $error("clock_divider: IN_HZ must be a multiple of 2*OUT_HZ");
    end
    if (HALF < 1) begin : g_bad_half
        $error("clock_divider: half period must be at least one cycle");
    end

    logic [CW-1:0] count;
    logic          wrap;
    logic          out_q;

    clockdiv_modcounter #(
        .MOD (HALF),
        .W   (CW)
    ) u_modcounter (
        .clk   (CLK_50MHz),
        .reset (reset),
        .cnt   (count),
        .wrap  (wrap)
    );

    // Toggle the output at the end of every half period.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
        end else if (wrap) begin
            out_q <= ~out_q;
        end
    end

    assign CLK_100Hz = out_q;

`ifdef CLOCKDIV_TICK_EN
    logic tick_q;

    // Pulse alongside the 0->1 toggle so consumers stay in the fast domain.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap & ~out_q;
        end
    end

    assign tick = tick_q;
`endif

    // The counter must never reach HALF.
    count_in_range: assert property (@(posedge CLK_50MHz) disable iff (reset)
                                     32'(count) < HALF);

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider over several divide ratios.
module tb_clock_divider;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    logic out_def, out5, out1, out37;
`ifdef CLOCKDIV_TICK_EN
    logic tick_def, tick5, tick1, tick37;
`endif

    clock_divider u_def (
        .CLK_50MHz (clk),
        .reset     (reset),
`ifdef CLOCKDIV_TICK_EN
        .tick      (tick_def),
`endif
        .CLK_100Hz (out_def)
    );

    clock_divider #(.IN_HZ(1000), .OUT_HZ(100)) u5 (
        .CLK_50MHz (clk),
        .reset     (reset),
`ifdef CLOCKDIV_TICK_EN
        .tick      (tick5),
`endif
        .CLK_100Hz (out5)
    );

    clock_divider #(.IN_HZ(200), .OUT_HZ(100)) u1 (
        .CLK_50MHz (clk),
        .reset     (reset),
`ifdef CLOCKDIV_TICK_EN
        .tick      (tick1),
`endif
        .CLK_100Hz (out1)
    );

    clock_divider #(.IN_HZ(7400), .OUT_HZ(100)) u37 (
        .CLK_50MHz (clk),
        .reset     (reset),
`ifdef CLOCKDIV_TICK_EN
        .tick      (tick37),
`endif
        .CLK_100Hz (out37)
    );

    // Reference: number of rising edges seen with reset low since the last reset.
    int unsigned edges;
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edges=%0d, t=%0t)",
                      name, act, exp, edges, $time);
    endtask

    // Output level after e edges: high during odd-numbered half periods.
    function automatic int exp_out(input int unsigned h);
        return int'((edges / h) % 2);
    endfunction

    // Tick is high in the cycle right after the output rose.
    function automatic int exp_tick(input int unsigned h);
        return (edges % (2 * h) == h) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("out_def", int'(out_def), exp_out(250_000));
        check("out5",    int'(out5),    exp_out(5));
        check("out1",    int'(out1),    exp_out(1));
        check("out37",   int'(out37),   exp_out(37));
        check("count5",  int'(u5.count), int'(edges % 5));
`ifdef CLOCKDIV_TICK_EN
        check("tick_def", int'(tick_def), exp_tick(250_000));
        check("tick5",    int'(tick5),    exp_tick(5));
        check("tick1",    int'(tick1),    exp_tick(1));
        check("tick37",   int'(tick37),   exp_tick(37));
`endif
    endtask

    typedef struct {
        int unsigned at_edges;
        logic        exp5;
        logic        exp1;
        int unsigned cnt5;
    } vec_t;

    vec_t tbl[$];

    // Count falling edges until 'sel' instance output changes; returns count.
    task automatic phase_len(input int sel, input int bound, output int n);
        logic start;
        logic cur;
        start = (sel == 5) ? out5 : out37;
        cur   = start;
        n     = 0;
        while (cur == start && n < bound) begin
            @(negedge clk);
            n++;
            cur = (sel == 5) ? out5 : out37;
        end
    endtask

    initial begin
        int n;
        int guard;

        // Hand-derived expectations for HALF=5 and HALF=1 after release.
        tbl.push_back('{0,  1'b0, 1'b0, 0});
        tbl.push_back('{1,  1'b0, 1'b1, 1});
        tbl.push_back('{4,  1'b0, 1'b0, 4});
        tbl.push_back('{5,  1'b1, 1'b1, 0});
        tbl.push_back('{6,  1'b1, 1'b0, 1});
        tbl.push_back('{9,  1'b1, 1'b1, 4});
        tbl.push_back('{10, 1'b0, 1'b0, 0});
        tbl.push_back('{15, 1'b1, 1'b1, 0});
        tbl.push_back('{20, 1'b0, 1'b0, 0});

        // Power-on reset, held across a clock edge.
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_out5",  int'(out5),  0);
        check("rst_out1",  int'(out1),  0);
        check("rst_out37", int'(out37), 0);
        #12 reset = 1'b0;

        // Table-driven checks against fixed edge counts.
        foreach (tbl[i]) begin
            guard = 0;
            while (edges < tbl[i].at_edges && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            check("tbl_reach", int'(edges), int'(tbl[i].at_edges));
            check("tbl_out5",  int'(out5),     int'(tbl[i].exp5));
            check("tbl_out1",  int'(out1),     int'(tbl[i].exp1));
            check("tbl_cnt5",  int'(u5.count), int'(tbl[i].cnt5));
        end

        // Phase lengths: every high and low phase is exactly HALF cycles.
        phase_len(5, 50, n);
        phase_len(5, 50, n);  check("phase5_a",  n, 5);
        phase_len(5, 50, n);  check("phase5_b",  n, 5);
        phase_len(37, 200, n);
        phase_len(37, 200, n); check("phase37_a", n, 37);
        phase_len(37, 200, n); check("phase37_b", n, 37);

        // Mid-high reset: output drops at once, next rise a full half period later.
        guard = 0;
        while (out37 !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_high_seen", int'(out37), 1);
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_out37", int'(out37), 0);
        check("mid_rst_out5",  int'(out5),  0);
        check("mid_rst_out1",  int'(out1),  0);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        n = 0;
        while (out37 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rise_after_rst", n, 37);

        // Randomized runs with asynchronous resets at random phases.
        for (int it = 0; it < 40; it++) begin
            int run;
            run = int'($urandom_range(1, 300));
            for (int c = 0; c < run; c++) begin
                @(negedge clk);
                check_all();
            end
            #($urandom_range(1, 8));
            reset = 1'b1;
            #1;
            check("rnd_rst_out5",  int'(out5),  0);
            check("rnd_rst_out37", int'(out37), 0);
            check("rnd_rst_out1",  int'(out1),  0);
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_all();
            end
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
# clock_divider

Derives a 50 %-duty 100 Hz clock from the 50 MHz board clock. It is the time base for the stopwatch's centisecond counters, so one output period is one 10 ms count step. It is a modulo counter that toggles the output every half period and is cleared by the global asynchronous reset.

## Interface
- IN_HZ, 50_000_000: input clock frequency in Hz.
- OUT_HZ, 100: output clock frequency in Hz.
- HALF (localparam), IN_HZ/(2*OUT_HZ) = 250_000: input cycles per output half period.
- CW (localparam), $clog2(HALF) = 18: counter width.
- CLK_50MHz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset. The clock is named as the codebase does; polarity and synchronicity are fixed.
- CLK_100Hz  output  1  divided clock, registered (never combinational).

## Operation
- Elaboration fails (`$error`) if:
  - IN_HZ is not an exact multiple of 2*OUT_HZ;
  - OUT_HZ is 0;
  - HALF is less than 1.
- Internal state:
  - count[CW-1:0], range 0..HALF-1;
  - out_q, which drives CLK_100Hz.
- While reset is high: count = 0 and out_q = 0. Both take effect immediately, without waiting for a clock edge.
- On each rising CLK_50MHz edge with reset low:
  - if count == HALF-1: count returns to 0 and out_q toggles;
  - otherwise count increments by 1 and out_q holds.
- Wrap-around: count never reaches HALF, and no other terminal state exists.
- If HALF == 1, out_q toggles on every edge (divide by 2).
- Reset mid-period: count and out_q clear at once. The next period starts from zero with full phase, so the first high phase after reset is a full half period.
- The output has no glitches: it is a single flop output.

## Timing
- Reset values: CLK_100Hz = 0 and count = 0.
- Measure from the first rising edge at which reset is low:
  - first rising edge of CLK_100Hz: after HALF = 250_000 rising edges (5 ms);
  - first falling edge of CLK_100Hz: after 500_000 rising edges (10 ms).
- Output period is exactly 2*HALF input cycles; high and low phases are exactly HALF cycles each.
- CLK_100Hz changes only a clock-to-Q delay after a CLK_50MHz rising edge.
- Reset assertion takes effect asynchronously. Deassertion is sampled at the next rising edge.

## Configuration
- CLOCKDIV_TICK_EN:
  - Defined: adds output tick (output, 1 bit, reset value 0). tick is high for exactly one CLK_50MHz cycle, in the same cycle that CLK_100Hz goes 0→1, i.e. registered together with the toggle. It lets downstream logic count in the 50 MHz domain instead of using CLK_100Hz as a clock.
  - Undefined: the port and its logic are absent, and the module has only the three ports listed above.

## Structure
- Shared package clockdiv_pkg holds:
  - CLK_IN_HZ = 50_000_000;
  - CLK_OUT_HZ = 100;
  - function half_count(in_hz, out_hz), returning in_hz/(2*out_hz).
- Top-level parameters default from the package constants.
- Sub-module clockdiv_modcounter:
  - parameters MOD and W;
  - ports: clk, reset, cnt[W-1:0], wrap (count == MOD-1);
  - the top level instantiates it once with MOD = HALF and toggles out_q on wrap.

## Test plan
- Power-on: hold reset high for 10 ns, then release → CLK_100Hz = 0 throughout reset. First rise is exactly 250_000 edges after release; first fall is 500_000 edges after release.
- Long run, 11 ms at 50 MHz (550_000 edges) → at least one full period. Each high and each low phase measures 250_000 edges (5_000_000 ns); period measures 10_000_000 ns.
- Mid-high reset: assert reset at edge 300_000 → CLK_100Hz drops to 0 within the same cycle. After release, the next rise is again 250_000 edges later.
- Small-parameter instance, IN_HZ = 1000 and OUT_HZ = 100 (HALF = 5) → output toggles every 5 edges. count sequence is 0..4 and then wraps to 0.
- Divide by 2, IN_HZ = 200 and OUT_HZ = 100 (HALF = 1) → output toggles on every edge.
- With CLOCKDIV_TICK_EN defined and HALF = 5 → tick is high for exactly one cycle, coincident with each 0→1 edge of CLK_100Hz. tick stays low during reset.
